// File: rtl/dcpu_intc.sv
// dcpu_intc: memory-mapped interrupt controller for the dcpu core.
// Captures rising edges on i_src into PEND, masks with EN and GIE, and serves an
// 8-word register window at BASE. Level-sensitive sources are built only when the
// DCPU_INTC_LEVEL_EN macro is defined.
module dcpu_intc #(
  parameter int unsigned  W    = 16,
  parameter int unsigned  NSRC = 8,
  parameter logic [W-1:0] BASE = 16'hFF00
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [W-1:0]    i_addr,
  input  logic [W-1:0]    i_dat,
  output logic [W-1:0]    o_dat,
  input  logic            i_we,
  input  logic            i_cs,
  output logic            o_ack,
  input  logic [NSRC-1:0] i_src,
  output logic            o_irq
);

  localparam logic [2:0] OffPend  = 3'd0;
  localparam logic [2:0] OffEn    = 3'd1;
  localparam logic [2:0] OffVec   = 3'd2;
  localparam logic [2:0] OffCtrl  = 3'd3;
`ifdef DCPU_INTC_LEVEL_EN
  localparam logic [2:0] OffLevel = 3'd4;
`endif

  typedef enum logic [0:0] {StIdle, StAck} state_e;

  state_e          state_q, state_d;
  logic [2:0]      off_q;
  logic            we_q;
  logic [NSRC-1:0] dat_q;
  logic            hit;
  logic            wr;
  logic [NSRC-1:0] s1_q, s2_q, s3_q;
  logic [NSRC-1:0] src_edge;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] en_q;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] active;
  logic            gie_q;
  logic            irq_q;
  logic [W-1:0]    vec;
  logic            unused_dat;
`ifdef DCPU_INTC_LEVEL_EN
  logic [NSRC-1:0] level_q;
`endif

  assign hit        = i_cs && (i_addr[W-1:3] == BASE[W-1:3]);
  assign wr         = (state_q == StAck) && we_q;
  assign src_edge   = s2_q & ~s3_q;
  assign active     = pend_q & en_q;
  assign o_irq      = irq_q;
  // Data bits above the source count never reach a register.
  assign unused_dat = ^i_dat[W-1:NSRC];

  // Bus FSM state and the access latched on a hit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      off_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && hit) begin
        off_q <= i_addr[2:0];
        we_q  <= i_we;
        dat_q <= i_dat[NSRC-1:0];
      end
    end
  end

  // Next state and ack: every hit gets exactly one ACK cycle, then back to IDLE.
  always_comb begin
    state_d = state_q;
    o_ack   = 1'b0;
    unique case (state_q)
      StIdle: if (hit) state_d = StAck;
      StAck: begin
        o_ack   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Three-flop chain per source; s2/s3 feed the edge detector.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= i_src;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Writable control registers commit on the edge that ends ACK.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      en_q    <= '0;
      gie_q   <= 1'b0;
`ifdef DCPU_INTC_LEVEL_EN
      level_q <= '0;
`endif
    end else if (wr) begin
      case (off_q)
        OffEn:    en_q    <= dat_q;
        OffCtrl:  gie_q   <= dat_q[0];
`ifdef DCPU_INTC_LEVEL_EN
        OffLevel: level_q <= dat_q;
`endif
        default: ;
      endcase
    end
  end

  // PEND next state: W1C then edge set, so a coincident edge wins.
  always_comb begin
    clr = '0;
    if (wr && off_q == OffPend) clr = dat_q;
    pend_d = (pend_q & ~clr) | src_edge;
`ifdef DCPU_INTC_LEVEL_EN
    // Level sources simply mirror the synchronised input.
    pend_d = (pend_d & ~level_q) | (s2_q & level_q);
`endif
  end

  // PEND and the registered interrupt request.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      irq_q  <= gie_q & (|active);
    end
  end

  // VEC: lowest-numbered pending & enabled source, or the "none" flag in the top bit.
  always_comb begin
    vec      = '0;
    vec[W-1] = 1'b1;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        vec      = '0;
        vec[3:0] = 4'(i);
      end
    end
  end

  // Read data is driven only during ACK, zero otherwise.
  always_comb begin
    o_dat = '0;
    if (state_q == StAck) begin
      case (off_q)
        OffPend:  o_dat[NSRC-1:0] = pend_q;
        OffEn:    o_dat[NSRC-1:0] = en_q;
        OffVec:   o_dat           = vec;
        OffCtrl:  o_dat[0]        = gie_q;
`ifdef DCPU_INTC_LEVEL_EN
        OffLevel: o_dat[NSRC-1:0] = level_q;
`endif
        default:  o_dat           = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dcpu_intc.sv
// tb_dcpu_intc: directed and randomized bench for dcpu_intc with a behavioural model.
module tb_dcpu_intc;

  localparam int unsigned  W    = 16;
  localparam int unsigned  NSRC = 8;
  localparam logic [W-1:0] BASE = 16'hFF00;

  logic            i_clk     = 1'b0;
  logic            i_reset_n = 1'b0;
  logic [W-1:0]    i_addr    = '0;
  logic [W-1:0]    i_dat     = '0;
  logic [W-1:0]    o_dat;
  logic            i_we      = 1'b0;
  logic            i_cs      = 1'b0;
  logic            o_ack;
  logic [NSRC-1:0] i_src     = '0;
  logic            o_irq;

  int checks = 0;
  int errors = 0;

  dcpu_intc #(.W(W), .NSRC(NSRC), .BASE(BASE)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_addr    (i_addr),
    .i_dat     (i_dat),
    .o_dat     (o_dat),
    .i_we      (i_we),
    .i_cs      (i_cs),
    .o_ack     (o_ack),
    .i_src     (i_src),
    .o_irq     (o_irq)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: register contents, an outstanding access, and the raw source
  // samples taken at the last three clock edges (h0 newest).
  logic [NSRC-1:0] m_pend = '0, m_en = '0, m_level = '0;
  logic [NSRC-1:0] h0 = '0, h1 = '0, h2 = '0;
  logic            m_gie = 1'b0, m_irq = 1'b0, m_busy = 1'b0, m_we = 1'b0;
  logic [2:0]      m_off = '0;
  logic [W-1:0]    m_wdat = '0;

  function automatic logic [W-1:0] m_read(input logic [2:0] off);
    logic [W-1:0] r;
    r = '0;
    case (off)
      3'd0: r[NSRC-1:0] = m_pend;
      3'd1: r[NSRC-1:0] = m_en;
      3'd2: begin
        r = 16'h8000;
        for (int i = 0; i < NSRC; i++) begin
          if (m_pend[i] && m_en[i]) begin
            r = W'(i);
            break;
          end
        end
      end
      3'd3: r[0] = m_gie;
`ifdef DCPU_INTC_LEVEL_EN
      3'd4: r[NSRC-1:0] = m_level;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  // Model update on each clock edge (or reset).
  initial begin
    logic [NSRC-1:0] clr, nxt;
    logic            irqn;
    forever begin
      @(posedge i_clk or negedge i_reset_n);
      if (!i_reset_n) begin
        m_pend = '0; m_en = '0; m_level = '0; m_gie = 1'b0; m_irq = 1'b0;
        m_busy = 1'b0; h0 = '0; h1 = '0; h2 = '0;
      end else begin
        irqn = m_gie & (|(m_pend & m_en));
        clr  = '0;
        if (m_busy && m_we && m_off == 3'd0) clr = m_wdat[NSRC-1:0];
        // A rise is seen when the source was high two edges ago and low three edges ago.
        for (int i = 0; i < NSRC; i++)
          nxt[i] = m_level[i] ? h1[i] : ((m_pend[i] & ~clr[i]) | (h1[i] & ~h2[i]));
        if (m_busy && m_we) begin
          case (m_off)
            3'd1: m_en = m_wdat[NSRC-1:0];
            3'd3: m_gie = m_wdat[0];
`ifdef DCPU_INTC_LEVEL_EN
            3'd4: m_level = m_wdat[NSRC-1:0];
`endif
            default: ;
          endcase
        end
        m_pend = nxt;
        m_irq  = irqn;
        if (m_busy) m_busy = 1'b0;
        else if (i_cs && (i_addr >> 3) == (BASE >> 3)) begin
          m_busy = 1'b1;
          m_off  = i_addr[2:0];
          m_we   = i_we;
          m_wdat = i_dat;
        end
        h2 = h1; h1 = h0; h0 = i_src;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      check("ack", o_ack, m_busy);
      check("rdata", o_dat, m_busy ? m_read(m_off) : '0);
      check("irq", o_irq, m_irq);
    end
  end

  task automatic bus(input logic we, input logic [2:0] off, input logic [W-1:0] d,
                     output logic [W-1:0] rd);
    int n;
    n = 0;
    @(negedge i_clk);
    i_cs = 1'b1; i_we = we; i_addr = BASE | W'(off); i_dat = d;
    do begin
      @(posedge i_clk);
      #1;
      n++;
    end while (!o_ack && n < 8);
    check("ack_wait", o_ack, 1'b1);
    rd = o_dat;
    @(negedge i_clk);
    i_cs = 1'b0; i_we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [W-1:0] d);
    logic [W-1:0] rd;
    bus(1'b1, off, d, rd);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] off, input logic [W-1:0] exp);
    logic [W-1:0] rd;
    bus(1'b0, off, '0, rd);
    check(name, rd, exp);
  endtask

  initial begin
    logic [W-1:0] r;
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;

    // Reset state
    check("irq_reset", o_irq, 1'b0);
    for (int k = 0; k < 8; k++) rd_chk("reset_read", 3'(k), (k == 2) ? 16'h8000 : 16'h0000);
    @(negedge i_clk);
    i_cs = 1'b1; i_addr = 16'h0100; i_we = 1'b0;
    repeat (3) begin
      @(posedge i_clk);
      #1;
      check("miss_ack", o_ack, 1'b0);
    end
    @(negedge i_clk);
    i_cs = 1'b0;

    // Single source to IRQ
    wr(3'd1, 16'h00FF);
    wr(3'd3, 16'h0001);
    @(negedge i_clk);
    i_src[5] = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 check("irq_edge3", o_irq, 1'b0);
    @(posedge i_clk);
    #1 check("irq_edge4", o_irq, 1'b1);
    rd_chk("pend_src5", 3'd0, 16'h0020);
    rd_chk("vec_src5", 3'd2, 16'h0005);
    wr(3'd0, 16'h0020);
    @(posedge i_clk);
    #1 check("irq_commit_edge", o_irq, 1'b1);
    @(posedge i_clk);
    #1 check("irq_after_w1c", o_irq, 1'b0);
    @(negedge i_clk);
    i_src[5] = 1'b0;

    // Priority and masking
    wr(3'd1, 16'h0040);
    @(negedge i_clk);
    i_src = 8'h44;
    repeat (4) @(negedge i_clk);
    i_src = '0;
    @(posedge i_clk);
    #1 check("irq_prio", o_irq, 1'b1);
    rd_chk("vec_6", 3'd2, 16'h0006);
    wr(3'd1, 16'h0044);
    rd_chk("vec_2", 3'd2, 16'h0002);
    wr(3'd3, 16'h0000);
    repeat (2) @(posedge i_clk);
    #1 check("irq_gie_off", o_irq, 1'b0);
    rd_chk("vec_gie_off", 3'd2, 16'h0002);

    // Set wins over a coincident W1C
    wr(3'd0, 16'h00FF);
    @(negedge i_clk);
    i_src[1] = 1'b1;
    wr(3'd0, 16'h0002);
    rd_chk("set_wins", 3'd0, 16'h0002);
    i_src[1] = 1'b0;

    // Held request: ack every other cycle, data zero outside ack
    @(negedge i_clk);
    i_cs = 1'b1; i_we = 1'b0; i_addr = BASE | 16'h0001;
    for (int k = 0; k < 4; k++) begin
      @(posedge i_clk);
      #1;
      check("hold_ack", o_ack, (k % 2) == 0);
      check("hold_dat", o_dat, ((k % 2) == 0) ? 16'h0044 : 16'h0000);
    end
    @(negedge i_clk);
    i_cs = 1'b0;

    // Reset during ACK of an EN write
    @(negedge i_clk);
    i_cs = 1'b1; i_we = 1'b1; i_addr = BASE | 16'h0001; i_dat = 16'h005A;
    @(posedge i_clk);
    #1 check("rst_ack", o_ack, 1'b1);
    i_reset_n = 1'b0;
    @(negedge i_clk);
    i_cs = 1'b0; i_we = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    rd_chk("en_after_rst", 3'd1, 16'h0000);

`ifdef DCPU_INTC_LEVEL_EN
    wr(3'd4, 16'h0001);
    @(negedge i_clk);
    i_src[0] = 1'b1;
    repeat (4) @(negedge i_clk);
    wr(3'd0, 16'h0001);
    rd_chk("level_hold", 3'd0, 16'h0001);
    @(negedge i_clk);
    i_src[0] = 1'b0;
    repeat (3) @(posedge i_clk);
    rd_chk("level_drop", 3'd0, 16'h0000);
    wr(3'd4, 16'h0000);
`else
    wr(3'd4, 16'hFFFF);
    rd_chk("off4_zero", 3'd4, 16'h0000);
`endif

    // Randomized traffic against the model
    for (int t = 0; t < 600; t++) begin
      @(negedge i_clk);
      if ($urandom_range(0, 2) == 0) i_src = NSRC'($urandom);
      case ($urandom_range(0, 4))
        0: @(negedge i_clk);
        1: begin
          i_cs   = 1'b1;
          i_we   = 1'($urandom);
          i_dat  = W'($urandom);
          i_addr = ($urandom_range(0, 1) == 0) ? (16'h0100 | W'($urandom_range(0, 255)))
                                               : (BASE ^ (W'(16'h0008) << $urandom_range(0, 12)));
          @(negedge i_clk);
          i_cs = 1'b0; i_we = 1'b0;
        end
        default: bus(1'($urandom), 3'($urandom_range(0, 7)), W'($urandom), r);
      endcase
    end

    repeat (3) @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
